uart_tx_stream: RTL and testbench

- Parametrised successor to the team's fixed 8N1 FIFO-buffered UART transmitter.
- Configurable data width, parity mode, stop-bit count and FIFO depth.
- Upstream writes use a valid/ready handshake, so producers stall instead of dropping data.
- Sits between on-chip producers (debug printers, command responders) and the board TX pin.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/uart_tx_stream.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_stream.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, TX FSM states and
// frame-timing helpers used by the TX path (and later RX).
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic int baud_divisor(input int freq, input int baud);
    return freq / baud;
  endfunction

  function automatic int frame_bits(input int data_bits,
                                    input int parity,
                                    input int stop_bits);
    return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == FULL_LVL);
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset; the cleared pointers discard old contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_tx_stream.sv
// FIFO-buffered UART transmitter with configurable frame format
// and a valid/ready write port.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BAUD_RATE       = 115200,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          tx_done
);

  localparam int DIV = baud_divisor(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST_BAUD = CW'(DIV - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic PAR_ODD = (PARITY == PARITY_ODD);
  localparam bit   HAS_PAR = (PARITY != PARITY_NONE);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_stream: baud divisor below 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_stream: DATA_BITS outside 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_stream: PARITY outside 0..2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_stream: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_stream: FIFO_DEPTH not a power of two >= 2");
  end

  tx_state_e            r_state;
  logic [CW-1:0]        r_baud;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_done;

  logic [DATA_BITS-1:0] w_head;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_tick;
  logic                 w_last_stop;
  logic                 w_pop;
  logic                 w_tx_next;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (wr_valid),
    .i_wdata (wr_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_level (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_tick      = (r_baud == LAST_BAUD);
  assign w_last_stop = (r_state == ST_STOP) && w_tick &&
                       (r_bit == LAST_STOP);
  assign w_pop       = !w_empty &&
                       ((r_state == ST_IDLE) || w_last_stop);

  assign wr_ready = !w_full;
  assign overflow = wr_valid && w_full;
  assign busy     = (r_state != ST_IDLE);
  assign tx       = r_tx;
  assign tx_done  = r_done;

  always_comb begin
    w_tx_next = 1'b1;
    unique case (r_state)
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = r_shift[0];
      ST_PARITY: w_tx_next = r_par;
      default:   w_tx_next = 1'b1;
    endcase
  end

  // tx and tx_done trail the state register by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_tx   <= w_tx_next;
      r_done <= w_last_stop;
      if (r_state == ST_IDLE || w_tick) r_baud <= '0;
      else r_baud <= r_baud + 1'b1;
      if (w_pop) begin
        r_shift <= w_head;
        r_par   <= (^w_head) ^ PAR_ODD;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (!w_empty) r_state <= ST_START;
        end
        ST_START: begin
          if (w_tick) begin
            r_state <= ST_DATA;
            r_bit   <= '0;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            if (r_bit == LAST_DATA) begin
              r_bit   <= '0;
              r_state <= HAS_PAR ? ST_PARITY : ST_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_state <= ST_STOP;
            r_bit   <= '0;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_bit == LAST_STOP) begin
              r_bit   <= '0;
              r_state <= w_empty ? ST_IDLE : ST_START;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Scoreboard bench: three uart_tx_stream instances (8N1, 7E2, 7O2)
// with words queued at write time and checked bit-by-bit on tx.
module tb_uart_tx_stream;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 250000;
  localparam int DIV    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_valid, a_ready, a_tx, a_busy, a_ovf, a_done;
  logic [7:0] a_data;
  logic [2:0] a_level;
  logic       b_valid, b_ready, b_tx, b_busy, b_ovf, b_done;
  logic [6:0] b_data;
  logic [2:0] b_level;
  logic       c_valid, c_ready, c_tx, c_busy, c_ovf, c_done;
  logic [6:0] c_data;
  logic [2:0] c_level;

  uart_tx_stream #(
    .CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_a (
    .clk(clk), .rst(rst), .wr_valid(a_valid), .wr_data(a_data),
    .wr_ready(a_ready), .tx(a_tx), .busy(a_busy),
    .fifo_level(a_level), .overflow(a_ovf), .tx_done(a_done)
  );

  uart_tx_stream #(
    .CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .wr_valid(b_valid), .wr_data(b_data),
    .wr_ready(b_ready), .tx(b_tx), .busy(b_busy),
    .fifo_level(b_level), .overflow(b_ovf), .tx_done(b_done)
  );

  uart_tx_stream #(
    .CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7),
    .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_dut_c (
    .clk(clk), .rst(rst), .wr_valid(c_valid), .wr_data(c_data),
    .wr_ready(c_ready), .tx(c_tx), .busy(c_busy),
    .fifo_level(c_level), .overflow(c_ovf), .tx_done(c_done)
  );

  logic [8:0] sb_a[$];
  logic [8:0] sb_b[$];
  logic [8:0] sb_c[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic get_tx(input int idx);
    case (idx)
      0:       return a_tx;
      1:       return b_tx;
      default: return c_tx;
    endcase
  endfunction

  function automatic logic get_done(input int idx);
    case (idx)
      0:       return a_done;
      1:       return b_done;
      default: return c_done;
    endcase
  endfunction

  task automatic sb_pop(input int idx, output logic [8:0] w,
                        output bit ok);
    ok = 1'b1;
    w  = '0;
    case (idx)
      0: if (sb_a.size() > 0) w = sb_a.pop_front(); else ok = 1'b0;
      1: if (sb_b.size() > 0) w = sb_b.pop_front(); else ok = 1'b0;
      default:
         if (sb_c.size() > 0) w = sb_c.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // Receive one frame; exp_gap < 0 skips the idle-gap check.
  task automatic rx_frame(input int idx, input int nbits,
                          input int par, input int nstop,
                          input int exp_gap);
    int gap, total, cyc, dn_cnt, dn_pos, ones, exp_smp;
    logic [15:0] smp;
    logic [8:0]  w;
    logic        e;
    bit          ok;
    gap = 0;
    @(negedge clk);
    while (get_tx(idx) !== 1'b0 && gap < 400) begin
      gap++;
      @(negedge clk);
    end
    if (gap >= 400) begin
      chk($sformatf("d%0d start timeout", idx), gap, 0);
      return;
    end
    if (exp_gap >= 0) chk($sformatf("d%0d gap", idx), gap, exp_gap);
    sb_pop(idx, w, ok);
    chk($sformatf("d%0d sb nonempty", idx), int'(ok), 1);
    ones = 0;
    for (int i = 0; i < nbits; i++) ones += int'(w[i]);
    total  = 1 + nbits + ((par != 0) ? 1 : 0) + nstop;
    cyc    = 0;
    dn_cnt = 0;
    dn_pos = 0;
    for (int b = 0; b < total; b++) begin
      smp = '0;
      for (int k = 0; k < DIV; k++) begin
        if (b != 0 || k != 0) @(negedge clk);
        cyc++;
        smp = {smp[14:0], get_tx(idx)};
        if (get_done(idx)) begin
          dn_cnt++;
          dn_pos = cyc;
        end
      end
      if (b == 0)          e = 1'b0;
      else if (b <= nbits) e = w[b-1];
      else if (par != 0 && b == nbits + 1)
        e = (par == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      else                 e = 1'b1;
      exp_smp = e ? ((1 << DIV) - 1) : 0;
      chk($sformatf("d%0d w%0h bit%0d", idx, w, b), int'(smp), exp_smp);
    end
    chk($sformatf("d%0d done count", idx), dn_cnt, 1);
    chk($sformatf("d%0d done pos", idx), dn_pos, total * DIV);
  endtask

  task automatic idle_check(input int idx, input int n);
    int lows, dones;
    lows  = 0;
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (get_tx(idx) !== 1'b1) lows++;
      if (get_done(idx) !== 1'b0) dones++;
    end
    chk($sformatf("d%0d idle tx lows", idx), lows, 0);
    chk($sformatf("d%0d idle done", idx), dones, 0);
  endtask

  initial begin
    int lvl_tab [6];
    logic [7:0] wa [6];
    lvl_tab = '{0, 1, 1, 2, 3, 4};
    wa      = '{8'h55, 8'hA3, 8'h0F, 8'hF0, 8'h81, 8'h3C};
    rst = 1'b1;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;
    c_valid = 1'b0; c_data = '0;
    repeat (3) @(negedge clk);
    chk("rst tx", a_tx, 1);
    chk("rst ready", a_ready, 1);
    chk("rst busy", a_busy, 0);
    chk("rst level", a_level, 0);
    chk("rst overflow", a_ovf, 0);
    chk("rst done", a_done, 0);
    rst = 1'b0;
    @(negedge clk);

    // 7E2 single word
    fork
      begin
        b_valid = 1'b1; b_data = 7'h03; sb_b.push_back(9'h003);
        @(negedge clk);
        b_valid = 1'b0;
      end
      rx_frame(1, 7, 2, 2, 2);
    join
    idle_check(1, 20);

    // 7O2 two words back-to-back
    fork
      begin
        c_valid = 1'b1; c_data = 7'h03; sb_c.push_back(9'h003);
        @(negedge clk);
        c_data = 7'h07; sb_c.push_back(9'h007);
        @(negedge clk);
        c_valid = 1'b0;
      end
      begin
        rx_frame(2, 7, 1, 2, 2);
        rx_frame(2, 7, 1, 2, 0);
      end
    join
    idle_check(2, 20);

    // 8N1 depth 4: fill, overflow, full push+pop, level-2 push+pop
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          a_valid = 1'b1;
          a_data  = wa[i];
          #1;
          chk($sformatf("a level pre%0d", i), a_level, lvl_tab[i]);
          chk($sformatf("a ready %0d", i), a_ready, (i < 5) ? 1 : 0);
          chk($sformatf("a ovf %0d", i), a_ovf, (i == 5) ? 1 : 0);
          chk($sformatf("a busy %0d", i), a_busy, (i >= 2) ? 1 : 0);
          if (i < 5) sb_a.push_back({1'b0, wa[i]});
          @(negedge clk);
        end
        a_valid = 1'b0;
        #1;
        chk("a level after reject", a_level, 4);
        chk("a ovf idle", a_ovf, 0);
        repeat (35) @(negedge clk);
        a_valid = 1'b1;
        a_data  = 8'hEE;
        #1;
        chk("a full pop ovf", a_ovf, 1);
        chk("a full pop ready", a_ready, 0);
        chk("a full pop level pre", a_level, 4);
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        chk("a full pop level post", a_level, 3);
        repeat (79) @(negedge clk);
        a_valid = 1'b1;
        a_data  = 8'h5A;
        #1;
        chk("a lvl2 ready", a_ready, 1);
        chk("a lvl2 ovf", a_ovf, 0);
        chk("a lvl2 level pre", a_level, 2);
        sb_a.push_back(9'h05A);
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        chk("a lvl2 level post", a_level, 2);
      end
      begin
        for (int f = 0; f < 6; f++)
          rx_frame(0, 8, 0, 1, (f == 0) ? 2 : 0);
      end
    join
    idle_check(0, 60);
    chk("a sb drained", sb_a.size(), 0);
    chk("a level end", a_level, 0);
    chk("a busy end", a_busy, 0);

    // reset during DATA with three words queued
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1;
      a_data  = wa[i];
      @(negedge clk);
    end
    a_valid = 1'b0;
    #1;
    chk("a queued level", a_level, 3);
    @(negedge clk);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst tx", a_tx, 1);
    chk("mid rst level", a_level, 0);
    chk("mid rst busy", a_busy, 0);
    chk("mid rst ready", a_ready, 1);
    chk("mid rst done", a_done, 0);
    rst = 1'b0;
    idle_check(0, 120);
    chk("post rst busy", a_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
